// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped GPIO port bank: register offsets,
// per-port address stride and parameter legality helpers.
package io_port_pkg;

  localparam int unsigned STRIDE = 8;

  typedef enum logic [2:0] {
    REG_OUT = 3'd0,
    REG_DDR = 3'd1,
    REG_PIN = 3'd2,
    REG_IFR = 3'd3,
    REG_IER = 3'd4
  } reg_sel_e;

  function automatic bit legal_ports(input int unsigned ports);
    return (ports == 1) || (ports == 2) || (ports == 4) || (ports == 8);
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchroniser for an asynchronous bus plus a one-cycle rising-edge
// pulse on the synchronised value.
module io_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0]            vld_q;
  logic [WIDTH-1:0]             prev_q;
  logic                         armed_q;

  // vld_q tracks which stages hold a real post-reset sample; edges are only
  // reported once prev_q holds one, so pins already high at release stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      vld_q   <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what makes this a shift chain and not a wire.
      stage_q <= {stage_q[STAGES-2:0], async_i};
      vld_q   <= {vld_q[STAGES-2:0], 1'b1};
      prev_q  <= stage_q[STAGES-1];
      armed_q <= vld_q[STAGES-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~prev_q & {WIDTH{armed_q}};

endmodule

// File: rtl/io_port_bank.sv
// Bank of 8-bit GPIO ports on a byte-wide CPU bus: output latch, direction,
// synchronised pin read, rising-edge interrupt flags and enables per port.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int unsigned PORTS       = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h8400,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_data_in,
  input  logic                 cpu_write_enable,
  output logic [7:0]           cpu_data_out,
  output logic                 hit,
  input  logic [8*PORTS-1:0]   port_in,
  output logic [8*PORTS-1:0]   port_out,
  output logic [8*PORTS-1:0]   port_oe,
  output logic                 irq
);

  localparam int unsigned BLK_BITS = $clog2(STRIDE * PORTS);

  if (!legal_ports(PORTS)) begin : g_bad_ports
    $error("io_port_bank: PORTS must be 1, 2, 4 or 8");
  end
  if ((BASE_ADDR % (STRIDE * PORTS)) != 0) begin : g_bad_base
    $error("io_port_bank: BASE_ADDR must be aligned to 8*PORTS bytes");
  end
  if ((SYNC_STAGES != 2) && (SYNC_STAGES != 3)) begin : g_bad_sync
    $error("io_port_bank: SYNC_STAGES must be 2 or 3");
  end

  logic [BLK_BITS-1:0] offset;
  logic [2:0]          reg_sel;
  logic [2:0]          port_sel;
  logic                addr_hit;
  logic [PORTS-1:0]    port_hit;

  logic [PORTS-1:0][7:0] out_q, out_d, ddr_q, ddr_d;
  logic [PORTS-1:0][7:0] ifr_q, ifr_d, ier_q, ier_d;
  logic [PORTS-1:0][7:0] ifr_clr, pin_s, pin_rise;
  logic [7:0]            rdata_d, rdata_q;
  logic                  hit_q, irq_d, irq_q;

  // The block is aligned, so a hit is just the upper address bits matching.
  assign addr_hit = (cpu_addr[15:BLK_BITS] == BASE_ADDR[15:BLK_BITS]);
  assign offset   = cpu_addr[BLK_BITS-1:0];
  assign reg_sel  = offset[2:0];
  assign port_sel = 3'(offset >> 3);

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    assign port_hit[g] = addr_hit && (port_sel == 3'(g));

    io_sync #(
      .WIDTH  (8),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (reset),
      .async_i (port_in[8*g +: 8]),
      .sync_o  (pin_s[g]),
      .rise_o  (pin_rise[g])
    );
  end

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves one unassigned and no latch is inferred.
    out_d   = out_q;
    ddr_d   = ddr_q;
    ier_d   = ier_q;
    ifr_clr = '0;
    ifr_d   = ifr_q;
    rdata_d = 8'h00;
    irq_d   = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (port_hit[p] && cpu_write_enable) begin
        case (reg_sel)
          REG_OUT: out_d[p]   = cpu_data_in;
          REG_DDR: ddr_d[p]   = cpu_data_in;
          REG_IFR: ifr_clr[p] = cpu_data_in;
          REG_IER: ier_d[p]   = cpu_data_in;
          default: ;
        endcase
      end
      // Set is ORed in after the clear so a coincident edge wins.
      ifr_d[p] = (ifr_q[p] & ~ifr_clr[p]) | (pin_rise[p] & ~ddr_q[p]);

      if (port_hit[p]) begin
        case (reg_sel)
          REG_OUT: rdata_d = out_q[p];
          REG_DDR: rdata_d = ddr_q[p];
          REG_PIN: rdata_d = pin_s[p];
          REG_IFR: rdata_d = ifr_q[p];
          REG_IER: rdata_d = ier_q[p];
          default: rdata_d = 8'h00;
        endcase
      end
      irq_d = irq_d | (|(ifr_q[p] & ier_q[p]));
    end
  end

  // NOTE: the per-port register file is small and software-visible, so every
  // entry is reset; large storage arrays would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      ddr_q   <= '0;
      ifr_q   <= '0;
      ier_q   <= '0;
      rdata_q <= 8'h00;
      hit_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      ddr_q   <= ddr_d;
      ifr_q   <= ifr_d;
      ier_q   <= ier_d;
      rdata_q <= rdata_d;
      hit_q   <= addr_hit;
      irq_q   <= irq_d;
    end
  end

  assign port_out     = out_q;
  assign port_oe      = ddr_q;
  assign cpu_data_out = rdata_q;
  assign hit          = hit_q;
  assign irq          = irq_q;

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter PORTS, default 2, number of 8-bit ports; legal values 1, 2, 4, 8.
REQ-002 Parameter BASE_ADDR, default 16'h8400, bus base address; aligned to 8*PORTS bytes.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal values 2 or 3.
REQ-004 clk  input  1  single block clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_addr  input  16  CPU address bus.
REQ-007 cpu_data_in  input  8  CPU write data.
REQ-008 cpu_write_enable  input  1  high = write cycle at cpu_addr.
REQ-009 cpu_data_out  output  8  registered read data.
REQ-010 hit  output  1  registered; high when the previous cycle's cpu_addr decoded into this block.
REQ-011 port_in  input  8*PORTS  external pin levels, asynchronous, port p at bits [8p+7:8p].
REQ-012 port_out  output  8*PORTS  output latch contents.
REQ-013 port_oe  output  8*PORTS  per-bit drive enable (equals DDR).
REQ-014 irq  output  1  registered interrupt request, active-high.

Function
REQ-015 Decode: access hits when cpu_addr[15:0] lies in BASE_ADDR .. BASE_ADDR+8*PORTS-1; port index = offset[5:3], register = offset[2:0].
REQ-016 Register map per port: 0 OUT (rw); 1 DDR (rw, 1 = output); 2 PIN (ro, synchronised pins); 3 IFR (read flags, write-1-to-clear); 4 IER (rw); 5-7 read 8'h00, writes ignored.
REQ-017 Writes take effect at the rising edge where cpu_write_enable=1 and the address hits.
REQ-018 Writes to PIN and to offsets 5-7 have no effect.
REQ-019 Reads: cpu_data_out and hit update every clk; latency one cycle from address to data; a non-hit cycle yields cpu_data_out=8'h00 and hit=0.
REQ-020 A read-after-write to the same register in consecutive cycles returns the newly written value.
REQ-021 Each port_in bit passes through SYNC_STAGES flops; PIN reflects the last stage.
REQ-022 Rising-edge detect: IFR bit sets when synchronised bit goes 0->1 on an input-configured bit (DDR=0); output bits never set IFR.
REQ-023 Simultaneous edge-set and write-1-to-clear on the same IFR bit: set wins.
REQ-024 Writing 0 bits to IFR leaves those bits unchanged.
REQ-025 irq = OR over all ports of (IFR & IER), registered; asserts one clk after the causing IFR/IER update.
REQ-026 Changing DDR from 0 to 1 does not clear existing IFR bits.
REQ-027 port_out = OUT and port_oe = DDR directly from registers, no extra latency.

Reset
REQ-028 While reset=0: OUT, DDR, IFR, IER, synchroniser flops, cpu_data_out = all zeros; hit=0; irq=0.
REQ-029 Reset asserts asynchronously mid-operation; deassertion is sampled on clk; no edge is reported for pins already high at deassertion (edge detector seeded from first synchronised sample).

Structure
REQ-030 Package io_port_pkg holds register offset constants (REG_OUT..REG_IER) and the stride value 8.
REQ-031 One sub-module io_sync: SYNC_STAGES-deep synchroniser plus rising-edge pulse for a width-parameterised bus, instantiated once per port.
REQ-032 Parameter legality (PORTS, BASE alignment, SYNC_STAGES) checked by elaboration-time assertions.

Verification (PORTS=2, BASE_ADDR=16'h8400, SYNC_STAGES=2)
REQ-033 Reset then read 8400..840F -> all cpu_data_out=8'h00, irq=0, port_oe=16'h0000.
REQ-034 Write 8400<=8'hA5, 8401<=8'h0F -> port_out[7:0]=8'hA5, port_oe[7:0]=8'h0F; read 8400 next cycle -> 8'hA5.
REQ-035 DDR1=0, IER1 (840C)<=8'h01, raise port_in[8] -> IFR1 (840B)=8'h01 after sync plus edge cycles, irq=1 one cycle later; write 840B<=8'h01 -> irq=0.
REQ-036 Same W1C write issued in the cycle a new edge sets bit 0 -> IFR1 stays 8'h01, irq stays 1.
REQ-037 Read 8410 (out of range) -> hit=0, cpu_data_out=8'h00; write 8410 -> no register changes.
REQ-038 Assert reset mid-transfer with port_in high -> all outputs zero immediately; after release no IFR bit sets.
